booth_mac_sequencer: RTL and testbench

//  Sequential radix-4 Booth multiply-accumulate controller for the NPU MAC unit.

---
 rtl/booth_mac_pkg.sv | 13 +
 rtl/Multiplier_Sub_Module.sv | 12 +
 rtl/booth_digit_decoder.sv | 13 +
 rtl/booth_mac_sequencer.sv | 121 ++++++++++++
 tb/tb_booth_mac_sequencer.sv | 131 +++++++++++++
 5 files changed

// File: rtl/booth_mac_pkg.sv
// booth_mac_pkg: shared FSM states, Booth digit codes and default sizing
package booth_mac_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [2:0] D_ZERO_LO = 3'b000;
  localparam logic [2:0] D_ZERO_HI = 3'b111;
  localparam logic [2:0] D_P2M     = 3'b011;
  localparam logic [2:0] D_M2M     = 3'b100;
  localparam int N_DEF     = 4;
  localparam int IDX_W_DEF = 2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/Multiplier_Sub_Module.sv
// Multiplier_Sub_Module: 5-bit one's-complement partial product of a 4-bit unsigned operand
module Multiplier_Sub_Module (
  input  logic [3:0] Multiplicant,
  input  logic       Shift,
  input  logic       Negation,
  input  logic       Zero,
  output logic [4:0] Result
);
  logic [3:0] m_x;
  assign m_x    = Multiplicant ^ {4{Negation}};
  assign Result = Zero ? 5'd0 : Shift ? {m_x, 1'b0} : {Negation, m_x};
endmodule

// File: rtl/booth_digit_decoder.sv
// booth_digit_decoder: radix-4 Booth triple to {shift, negate, zero} controls
module booth_digit_decoder
  import booth_mac_pkg::*;
(
  input  logic [2:0] triple_i,
  output logic       shift_o,
  output logic       neg_o,
  output logic       zero_o
);
  assign zero_o  = (triple_i == D_ZERO_LO) || (triple_i == D_ZERO_HI);
  assign shift_o = (triple_i == D_P2M) || (triple_i == D_M2M);
  assign neg_o   = triple_i[2] & ~zero_o;
endmodule

// File: rtl/booth_mac_sequencer.sv
// booth_mac_sequencer: sequential radix-4 Booth multiply-accumulate with valid/ready result
module booth_mac_sequencer
  import booth_mac_pkg::*;
#(
  parameter int B_W   = 8,
  parameter int ACC_W = 20
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    In_Valid,
  output logic                    In_Ready,
  input  logic [3:0]              Multiplicant,
  input  logic [B_W-1:0]          Multiplier,
  input  logic                    Acc_Clear,
  output logic                    Out_Valid,
  input  logic                    Out_Ready,
  output logic signed [ACC_W-1:0] Acc_Out,
  output logic                    Overflow,
  output logic                    Busy
);
  localparam int N  = B_W / 2;
  localparam int IW = idx_w(N);
  state_e                   state_q, state_d;
  logic [3:0]               a_q, a_d;
  logic [B_W:0]             b_q, b_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_out_q, acc_out_d;
  logic                     ovf_q, ovf_d, out_valid_q, out_valid_d;
  logic                     shift, neg, zero, last, ovf_add;
  logic [4:0]               result;
  logic signed [ACC_W-1:0]  pp, weighted, sum;
  // b_q is shifted right two bits per digit, so the current triple is always its low bits
  booth_digit_decoder u_dec (
    .triple_i(b_q[2:0]),
    .shift_o (shift),
    .neg_o   (neg),
    .zero_o  (zero)
  );
  Multiplier_Sub_Module u_mul (
    .Multiplicant(a_q),
    .Shift       (shift),
    .Negation    (neg),
    .Zero        (zero),
    .Result      (result)
  );
  // One-extended negatives need +1 (plain) or +2 (shifted, LSB was forced to 0) to become two's complement
  always_comb begin
    pp       = neg ? {{(ACC_W-5){1'b1}}, result} + {{(ACC_W-2){1'b0}}, shift, ~shift}
                   : {{(ACC_W-5){1'b0}}, result};
    weighted = pp << {idx_q, 1'b0};
    sum      = acc_q + weighted;
    ovf_add  = (acc_q[ACC_W-1] == weighted[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    last     = idx_q == IW'(N-1);
  end
  // Next-state and datapath update for IDLE accept/clear, RUN digit add, DONE handshake
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (state_q == IDLE) begin
      if (In_Valid) begin
        state_d = RUN;
        a_d     = Multiplicant;
        b_d     = {Multiplier, 1'b0};
        idx_d   = '0;
        if (Acc_Clear) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
      end else if (Acc_Clear) begin
        acc_d     = '0;
        acc_out_d = '0;
      end
    end else if (state_q == RUN) begin
      acc_d = sum;
      ovf_d = ovf_q | ovf_add;
      b_d   = b_q >> 2;
      idx_d = last ? '0 : idx_q + 1'b1;
      if (last) begin
        state_d     = DONE;
        acc_out_d   = sum;
        out_valid_d = 1'b1;
      end
    end else if (Out_Ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign In_Ready  = state_q == IDLE;
  assign Busy      = state_q != IDLE;
  assign Out_Valid = out_valid_q;
  assign Acc_Out   = acc_out_q;
  assign Overflow  = ovf_q;
endmodule

// File: tb/tb_booth_mac_sequencer.sv
// tb_booth_mac_sequencer: directed checks of the Booth MAC sequencer at ACC_W=20 and ACC_W=12
module tb_booth_mac_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, acc_clear = 1'b0, out_ready = 1'b0;
  logic [3:0] mcand = '0;
  logic [7:0] mplier = '0;
  logic in_ready, out_valid, ovf, busy;
  logic signed [19:0] acc_out;
  logic in_ready12, out_valid12, ovf12, busy12;
  logic signed [11:0] acc_out12;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  booth_mac_sequencer #(.B_W(8), .ACC_W(20)) dut (
    .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid), .In_Ready(in_ready),
    .Multiplicant(mcand), .Multiplier(mplier), .Acc_Clear(acc_clear),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Acc_Out(acc_out),
    .Overflow(ovf), .Busy(busy)
  );
  booth_mac_sequencer #(.B_W(8), .ACC_W(12)) dut12 (
    .Clk(clk), .Rst_n(rst_n), .In_Valid(in_valid), .In_Ready(in_ready12),
    .Multiplicant(mcand), .Multiplier(mplier), .Acc_Clear(acc_clear),
    .Out_Valid(out_valid12), .Out_Ready(out_ready), .Acc_Out(acc_out12),
    .Overflow(ovf12), .Busy(busy12)
  );
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic start_op(input logic [3:0] a, input logic [7:0] b, input logic clr);
    @(negedge clk);
    in_valid = 1'b1; mcand = a; mplier = b; acc_clear = clr;
    @(posedge clk);
    #1 in_valid = 1'b0; acc_clear = 1'b0;
  endtask
  task automatic run_op(input logic [3:0] a, input logic [7:0] b, input logic clr);
    int n;
    start_op(a, b, clr);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", n, 4);
  endtask
  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("ov_fall", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
  endtask
  initial begin
    #12;
    chk("rst_acc", acc_out, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    run_op(4'd7, 8'd3, 1'b1);
    chk("t1_acc", acc_out, 21);
    chk("t1_ovf", ovf, 0);
    chk("t1_busy", busy, 1);
    release_out();
    run_op(4'd15, 8'h80, 1'b1);
    chk("t2_neg", acc_out, -1920);
    release_out();
    run_op(4'd0, 8'hFF, 1'b1);
    chk("t2_zero", acc_out, 0);
    release_out();
    run_op(4'd15, 8'd127, 1'b1);
    chk("t3_first", acc_out, 1905);
    release_out();
    run_op(4'd15, 8'd127, 1'b0);
    chk("t3_accum", acc_out, 3810);
    release_out();
    @(negedge clk);
    acc_clear = 1'b1;
    @(posedge clk);
    #1 acc_clear = 1'b0;
    chk("t3_idle_clr", acc_out, 0);
    run_op(4'd5, 8'd6, 1'b1);
    chk("t4_acc", acc_out, 30);
    in_valid = 1'b1; mcand = 4'd9; mplier = 8'd9; acc_clear = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t4_hold_ov", out_valid, 1);
      chk("t4_hold_acc", acc_out, 30);
      chk("t4_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; acc_clear = 1'b0;
    release_out();
    chk("t4_no_accept", busy, 0);
    chk("t4_acc_kept", acc_out, 30);
    run_op(4'd15, 8'd127, 1'b1);
    chk("t5_first", acc_out12, 1905);
    chk("t5_ovf0", ovf12, 0);
    release_out();
    run_op(4'd15, 8'd127, 1'b0);
    chk("t5_wrap", acc_out12, -286);
    chk("t5_ovf1", ovf12, 1);
    release_out();
    run_op(4'd7, 8'd3, 1'b1);
    chk("t5_clr_acc", acc_out12, 21);
    chk("t5_clr_ovf", ovf12, 0);
    release_out();
    start_op(4'd9, 8'd9, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_acc", acc_out, 0);
    chk("t6_ov", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd3, 8'hFB, 1'b1);
    chk("t6_after", acc_out, -15);
    release_out();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
